// File: rtl/load_store_unit.sv
// load_store_unit: CPU byte/half/word load-store front end for a 1-cycle synchronous word RAM
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake (ready only in IDLE)
//   req_we/size/signed/addr/wdata  request fields (size 00 byte, 01 half, 10 word)
//   resp_valid/err/rdata     one-cycle completion pulse, error flag, load data
//   mem_addr/in/we, mem_out  word-indexed RAM port, read data one cycle after address
module load_store_unit #(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_in,
    output logic        mem_we,
    input  logic [31:0] mem_out
);
    localparam logic [1:0] S_IDLE = 2'd0, S_LD = 2'd1, S_RMW = 2'd2;
    logic [1:0]  r_state;
    logic [31:0] r_addr, r_wdata;
    logic [1:0]  r_size;
    logic        r_signed;
    logic        w_idle, w_accept, w_mis, w_word_st;
    logic [4:0]  w_sh;
    logic [31:0] w_lane, w_ext, w_mask, w_merge;
    assign w_idle    = r_state == S_IDLE;
    assign req_ready = w_idle;
    assign w_accept  = req_valid & w_idle;
    assign w_mis     = (req_size == 2'b11) | (req_size == 2'b01 & req_addr[0]) | (req_size == 2'b10 & |req_addr[1:0]);
    assign w_word_st = req_we & (req_size == 2'b10);
    // Bit position of the addressed lane; big-endian puts offset 0 in the top byte.
    assign w_sh    = BIG_ENDIAN ? {(r_size == 2'b00) ? ~r_addr[1:0] : {~r_addr[1], 1'b0}, 3'b000}
                                : {r_addr[1:0], 3'b000};
    assign w_lane  = mem_out >> w_sh;
    assign w_ext   = (r_size == 2'b00) ? {{24{r_signed & w_lane[7]}}, w_lane[7:0]} :
                     (r_size == 2'b01) ? {{16{r_signed & w_lane[15]}}, w_lane[15:0]} : mem_out;
    assign w_mask  = ((r_size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << w_sh;
    assign w_merge = (mem_out & ~w_mask) | ((r_wdata << w_sh) & w_mask);
    assign mem_addr = {2'b00, w_idle ? req_addr[31:2] : r_addr[31:2]};
    assign mem_in   = w_idle ? req_wdata : w_merge;
    assign mem_we   = ~rst & ((w_accept & ~w_mis & w_word_st) | (r_state == S_RMW));
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            if (w_accept) begin
                r_addr   <= req_addr;
                r_size   <= req_size;
                r_signed <= req_signed;
                r_wdata  <= req_wdata;
            end
            case (r_state)
                S_IDLE: if (w_accept) begin
                    // Errors and word stores finish in the accept cycle; the rest need the RAM read.
                    if (w_mis | w_word_st) begin
                        resp_valid <= 1'b1;
                        resp_err   <= w_mis;
                    end else begin
                        r_state <= req_we ? S_RMW : S_LD;
                    end
                end
                S_LD: begin
                    resp_valid <= 1'b1;
                    resp_rdata <= w_ext;
                    r_state    <= S_IDLE;
                end
                default: begin
                    resp_valid <= r_state == S_RMW;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end
endmodule
